// File: rtl/core_ctrl.sv
// core_ctrl: multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer with trap entry.
// Ports: i_clk/rst_n, decode fields, mem acks in; req/we strobes, trap info out.
module core_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        rst_n,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [4:0]  i_rd,
  input  logic [11:0] i_imm,
  input  logic        i_addr_misaligned,
  input  logic        i_target_misaligned,
  input  logic        i_imem_ack,
  input  logic        i_dmem_ack,
  output logic        o_imem_req,
  output logic        o_ir_we,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic        o_rf_we,
  output logic        o_pc_we,
  output logic        o_retire,
  output logic        o_trap,
  output logic [3:0]  o_trap_cause,
  output logic [2:0]  o_state
);

  localparam logic [2:0] S_BOOT   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  // Keep at least one counter bit so a disabled timeout still elaborates.
  localparam int CW =
    (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT =
    CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [2:0]    state;
  logic [2:0]    state_nx;
  logic [3:0]    cause;
  logic [3:0]    cause_nx;
  logic [CW-1:0] cnt;
  logic          tmo;
  logic          waiting;

  logic is_load, is_store, is_branch, is_jal, is_jalr;
  logic is_lui, is_auipc, is_opimm, is_op, is_sys, is_fence;
  logic legal, writes_rd;

  assign is_load   = i_opcode == OP_LOAD;
  assign is_store  = i_opcode == OP_STORE;
  assign is_branch = i_opcode == OP_BRANCH;
  assign is_jal    = i_opcode == OP_JAL;
  assign is_jalr   = i_opcode == OP_JALR;
  assign is_lui    = i_opcode == OP_LUI;
  assign is_auipc  = i_opcode == OP_AUIPC;
  assign is_opimm  = i_opcode == OP_OPIMM;
  assign is_op     = i_opcode == OP_OP;
  assign is_sys    = i_opcode == OP_SYSTEM;
  assign is_fence  = i_opcode == OP_FENCE;

  assign legal = is_load | is_store | is_branch | is_jal
    | is_jalr | is_lui | is_auipc | is_opimm | is_op
    | is_sys | is_fence;

  // SYSTEM with funct3 != 0 is a CSR access that returns rd.
  assign writes_rd = is_load | is_jal | is_jalr | is_lui
    | is_auipc | is_opimm | is_op
    | (is_sys && i_funct3 != 3'd0);

  assign waiting = (state == S_FETCH) || (state == S_MEM);
  assign tmo = (MEM_TIMEOUT != 0) && (cnt == LIMIT);

  always_comb begin
    state_nx = state;
    cause_nx = cause;
    unique case (state)
      S_BOOT:   state_nx = S_FETCH;
      S_FETCH: begin
        if (i_imem_ack) begin
          state_nx = S_DECODE;
        end else if (tmo) begin
          state_nx = S_TRAP;
          cause_nx = 4'd1;
        end
      end
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        // Priority order matters: first matching condition wins.
        state_nx = S_TRAP;
        if (!legal) begin
          cause_nx = 4'd2;
        end else if (is_sys && i_funct3 == 3'd4) begin
          cause_nx = 4'd2;
        end else if (is_sys && i_funct3 == 3'd0) begin
          if (i_imm == 12'h000)      cause_nx = 4'd11;
          else if (i_imm == 12'h001) cause_nx = 4'd3;
          else                       cause_nx = 4'd2;
        end else if (is_load && i_addr_misaligned) begin
          cause_nx = 4'd4;
        end else if (is_store && i_addr_misaligned) begin
          cause_nx = 4'd6;
        end else if ((is_branch | is_jal | is_jalr)
                     && i_target_misaligned) begin
          cause_nx = 4'd0;
        end else if (is_load | is_store) begin
          state_nx = S_MEM;
        end else begin
          state_nx = S_WB;
        end
      end
      S_MEM: begin
        if (i_dmem_ack) begin
          state_nx = S_WB;
        end else if (tmo) begin
          state_nx = S_TRAP;
          cause_nx = is_store ? 4'd7 : 4'd5;
        end
      end
      S_WB:     state_nx = S_FETCH;
      S_TRAP:   state_nx = S_FETCH;
      default:  state_nx = S_BOOT;
    endcase
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_BOOT;
      cause <= 4'd0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cause <= cause_nx;
      if (state_nx != state) cnt <= '0;
      else if (waiting && cnt != '1) cnt <= cnt + 1'b1;
    end
  end

  assign o_imem_req   = state == S_FETCH;
  assign o_ir_we      = (state == S_FETCH) && i_imem_ack;
  assign o_dmem_req   = state == S_MEM;
  assign o_dmem_we    = (state == S_MEM) && is_store;
  assign o_rf_we      = (state == S_WB) && writes_rd
                        && (i_rd != 5'd0);
  assign o_pc_we      = (state == S_WB) || (state == S_TRAP);
  assign o_retire     = state == S_WB;
  assign o_trap       = state == S_TRAP;
  assign o_trap_cause = cause;
  assign o_state      = state;

endmodule
